// File: rtl/mcdf_fmt_receiver.sv
// Downstream receiver for the MCDF formatter: grants packets against free buffer space,
// captures bursts into a tagged word FIFO, flags protocol errors and streams words out.
module mcdf_fmt_receiver #(
  parameter int unsigned DATA_WIDE = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned PTR_WIDE  = 5,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fmt_req,
  input  logic [1:0]           fmt_chid,
  input  logic [5:0]           fmt_length,
  output logic                 fmt_grant,
  input  logic                 fmt_start,
  input  logic                 fmt_end,
  input  logic [DATA_WIDE-1:0] fmt_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_WIDE-1:0] rx_data,
  output logic [1:0]           rx_chid,
  output logic                 rx_last,
  output logic [PTR_WIDE:0]    rx_free,
  output logic [15:0]          pkt_cnt,
  output logic [2:0]           err_flags,
  input  logic                 err_clr,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECV} state_t;

  localparam logic [PTR_WIDE:0] DEPTH_W = (PTR_WIDE + 1)'(DEPTH);
  localparam logic [7:0]        TMO_MAX = 8'(TIMEOUT - 1);

  state_t                state;
  logic [1:0]            chid_q;
  logic [5:0]            len_q;
  logic [5:0]            cnt_q;
  logic [7:0]            tmo_q;
  logic [PTR_WIDE-1:0]   wr_ptr;
  logic [PTR_WIDE-1:0]   rd_ptr;
  logic [PTR_WIDE:0]     count;
  logic [DATA_WIDE+2:0]  mem [DEPTH];

  logic                  push;
  logic                  pop;
  logic                  grant_ok;
  logic [5:0]            word_num;
  logic                  len_hit;
  logic                  word_last;
  logic [2:0]            err_set;
  logic [DATA_WIDE+2:0]  head;

  always_comb begin
    rx_free   = DEPTH_W - count;
    rx_valid  = (count != '0);
    pop       = rx_valid && rx_ready;
    push      = (state == WAIT_START && fmt_start) || (state == RECV);
    grant_ok  = (state == IDLE) && fmt_req && (fmt_length != 6'd0) &&
                (32'(fmt_length) <= 32'(rx_free));
    word_num  = (state == WAIT_START) ? 6'd1 : cnt_q + 6'd1;
    len_hit   = (word_num == len_q);
    word_last = fmt_end || len_hit;
    err_set   = 3'b000;
    // Length error: zero-length request, or end marker and length count disagree.
    err_set[0] = ((state == IDLE) && fmt_req && (fmt_length == 6'd0)) ||
                 (push && (fmt_end != len_hit));
    err_set[1] = (state == WAIT_START) && !fmt_start && (tmo_q == TMO_MAX);
    err_set[2] = grant_ok && (fmt_chid == 2'd3);
    head      = mem[rd_ptr];
    rx_data   = rx_valid ? head[DATA_WIDE-1:0] : '0;
    rx_last   = rx_valid ? head[DATA_WIDE] : 1'b0;
    rx_chid   = rx_valid ? head[DATA_WIDE+2:DATA_WIDE+1] : 2'd0;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fmt_grant <= 1'b0;
      chid_q    <= 2'd0;
      len_q     <= 6'd0;
      cnt_q     <= 6'd0;
      tmo_q     <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_cnt   <= 16'd0;
      err_flags <= 3'b000;
    end else begin
      fmt_grant <= (state == GRANT);
      err_flags <= (err_clr ? 3'b000 : err_flags) | err_set;
      unique case (state)
        IDLE: begin
          if (grant_ok) begin
            chid_q <= fmt_chid;
            len_q  <= fmt_length;
            state  <= GRANT;
          end
        end
        GRANT: begin
          tmo_q <= 8'd0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (fmt_start) begin
            cnt_q <= 6'd1;
            state <= word_last ? IDLE : RECV;
          end else if (tmo_q == TMO_MAX) begin
            state <= IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        RECV: begin
          cnt_q <= word_num;
          if (word_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Space was reserved at grant time, so the push never checks for full.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (word_last) pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_WIDE{1'b0}}, push} - {{PTR_WIDE{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {chid_q, word_last, fmt_data};
  end

endmodule

// File: tb/tb_mcdf_fmt_receiver.sv
// Directed/randomised bench for mcdf_fmt_receiver against a queue-based packet model.
module tb_mcdf_fmt_receiver;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        fmt_req, fmt_start, fmt_end, rx_ready, err_clr;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic [31:0] fmt_data;
  logic        fmt_grant, rx_valid, rx_last, busy;
  logic [31:0] rx_data;
  logic [1:0]  rx_chid;
  logic [5:0]  rx_free;
  logic [15:0] pkt_cnt;
  logic [2:0]  err_flags;

  typedef struct {
    logic [1:0]  chid;
    logic        last;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned m_pkt;
  logic [2:0]  m_err;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  mcdf_fmt_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .fmt_req    (fmt_req),
    .fmt_chid   (fmt_chid),
    .fmt_length (fmt_length),
    .fmt_grant  (fmt_grant),
    .fmt_start  (fmt_start),
    .fmt_end    (fmt_end),
    .fmt_data   (fmt_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_chid    (rx_chid),
    .rx_last    (rx_last),
    .rx_free    (rx_free),
    .pkt_cnt    (pkt_cnt),
    .err_flags  (err_flags),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(m_pkt & 32'hFFFF));
    check({tag, "_err"}, 64'(err_flags), 64'(m_err));
    check({tag, "_free"}, 64'(rx_free), 64'(DEPTH - exp_q.size()));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Request, wait for the grant, then stream words starting the cycle after the grant.
  task automatic send_pkt(input logic [1:0] chid, input int len, input int end_at,
                          input bit fixed, input logic [31:0] base, input bit chk_lat);
    int n;
    int nw;
    logic [31:0] d;
    fmt_req    = 1'b1;
    fmt_chid   = chid;
    fmt_length = len[5:0];
    n = 0;
    while (!fmt_grant && n < 60) begin
      tick();
      n++;
    end
    check("grant_seen", 64'(fmt_grant), 64'd1);
    if (chk_lat) check("grant_latency", 64'(n), 64'd2);
    fmt_req = 1'b0;
    tick();
    check("grant_single", 64'(fmt_grant), 64'd0);
    nw = (end_at < len) ? end_at : len;
    for (int i = 1; i <= nw; i++) begin
      d = fixed ? base + 32'(i - 1) : $urandom;
      fmt_start = (i == 1);
      fmt_end   = (i == end_at);
      fmt_data  = d;
      exp_q.push_back('{chid: chid, last: (i == nw), data: d});
      tick();
    end
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    m_pkt++;
    if (end_at != len) m_err[0] = 1'b1;
    if (chid == 2'd3) m_err[2] = 1'b1;
  endtask

  task automatic drain(input int n);
    int popped = 0;
    int guard  = 0;
    ent_t e;
    rx_ready = 1'b1;
    while (popped < n && guard < 4 * n + 10) begin
      if (rx_valid) begin
        e = exp_q.pop_front();
        check("rx_data", 64'(rx_data), 64'(e.data));
        check("rx_chid", 64'(rx_chid), 64'(e.chid));
        check("rx_last", 64'(rx_last), 64'(e.last));
        popped++;
      end
      tick();
      guard++;
    end
    rx_ready = 1'b0;
    check("drain_count", 64'(popped), 64'(n));
  endtask

  initial begin
    int len;
    rst = 1'b1; fmt_req = 1'b0; fmt_start = 1'b0; fmt_end = 1'b0; rx_ready = 1'b0;
    err_clr = 1'b0; fmt_chid = 2'd0; fmt_length = 6'd0; fmt_data = 32'd0;
    m_pkt = 0; m_err = 3'b000;
    tick(); tick();
    check("rst_grant", 64'(fmt_grant), 64'd0);
    check("rst_valid", 64'(rx_valid), 64'd0);
    check("rst_data", 64'(rx_data), 64'd0);
    check_status("rst");
    rst = 1'b0;
    tick();

    // Normal packet
    send_pkt(2'd1, 4, 4, 1'b1, 32'hA0, 1'b1);
    check_status("normal");
    drain(4);

    // Randomised well-formed packets
    for (int p = 0; p < 6; p++) begin
      len = int'($urandom_range(1, 8));
      send_pkt(2'($urandom_range(0, 2)), len, len, 1'b0, 32'd0, 1'b1);
      check_status("rand");
      if (p % 2 == 1) drain(exp_q.size());
    end
    drain(exp_q.size());

    // Backpressure: fill 24 of 32 entries, then request 16 words
    for (int p = 0; p < 3; p++) send_pkt(2'(p), 8, 8, 1'b0, 32'd0, 1'b0);
    check_status("bp_fill");
    check("bp_free8", 64'(rx_free), 64'd8);
    fmt_req = 1'b1; fmt_chid = 2'd2; fmt_length = 6'd16;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_no_grant", 64'(fmt_grant), 64'd0);
    end
    drain(7);
    tick(); tick();
    check("bp_no_grant_15", 64'(fmt_grant), 64'd0);
    drain(1);
    send_pkt(2'd2, 16, 16, 1'b0, 32'd0, 1'b0);
    check_status("bp_full");
    check("bp_full_free", 64'(rx_free), 64'd0);
    drain(32);

    // Length mismatch: end marker early
    send_pkt(2'd0, 8, 5, 1'b0, 32'd0, 1'b1);
    check_status("mismatch");
    drain(5);
    err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 3'b000;
    check("clr1", 64'(err_flags), 64'd0);

    // Start timeout
    fmt_req = 1'b1; fmt_chid = 2'd0; fmt_length = 6'd4;
    tick(); tick();
    check("tmo_grant", 64'(fmt_grant), 64'd1);
    fmt_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("tmo_busy_mid", 64'(busy), 64'd1);
    check("tmo_err_mid", 64'(err_flags), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    m_err[1] = 1'b1;
    check_status("tmo");
    check("tmo_valid", 64'(rx_valid), 64'd0);

    // chid 3 stored with flag, zero-length request refused
    err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 3'b000;
    send_pkt(2'd3, 4, 4, 1'b0, 32'd0, 1'b1);
    check_status("chid3");
    fmt_req = 1'b1; fmt_chid = 2'd0; fmt_length = 6'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("len0_no_grant", 64'(fmt_grant), 64'd0);
    end
    fmt_req = 1'b0;
    tick();
    m_err[0] = 1'b1;
    check_status("len0");
    drain(4);
    err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 3'b000;
    check("clr2", 64'(err_flags), 64'd0);

    // Reset in the middle of a packet
    fmt_req = 1'b1; fmt_chid = 2'd1; fmt_length = 6'd4;
    tick(); tick();
    fmt_req = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      fmt_start = (i == 0); fmt_data = $urandom;
      tick();
    end
    fmt_start = 1'b0;
    check("mid_valid_before", 64'(rx_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); m_pkt = 0; m_err = 3'b000;
    check("mid_rst_valid", 64'(rx_valid), 64'd0);
    check_status("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    send_pkt(2'd2, 3, 3, 1'b0, 32'd0, 1'b1);
    check_status("post_rst");
    drain(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mcdf_fmt_receiver.md
Name: mcdf_fmt_receiver

Overview:
- Downstream consumer of the MCDF formatter packet interface; replaces the external bench/slave that drives fmt_grant.
- Arbitrates grant against local buffer space and captures each burst (fmt_start..fmt_end) into a tagged word FIFO.
- Checks packet length and channel ID, counts completed packets, and presents words on a valid/ready stream to the next stage.

Parameters:
- DATA_WIDE, 32, data word width (matches fmt_data).
- DEPTH, 32, receive FIFO depth in words; must be a power of two and at least 32 (largest formatter packet).
- PTR_WIDE, 5, log2(DEPTH).
- TIMEOUT, 15, maximum cycles from the grant pulse to fmt_start.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- fmt_req  in  1  formatter has a packet pending; held until granted.
- fmt_chid  in  2  channel of the pending/current packet; valid with fmt_req.
- fmt_length  in  6  words in the pending packet; valid with fmt_req.
- fmt_grant  out  1  one-cycle grant pulse.
- fmt_start  in  1  marks the first data word.
- fmt_end  in  1  marks the last data word.
- fmt_data  in  DATA_WIDE  packet word.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  downstream accepts the head word.
- rx_data  out  DATA_WIDE  head word data.
- rx_chid  out  2  head word channel tag.
- rx_last  out  1  head word is the last word of its packet.
- rx_free  out  PTR_WIDE+1  free FIFO entries.
- pkt_cnt  out  16  packets completed; wraps from 0xFFFF to 0.
- err_flags  out  3  sticky flags: [0] length mismatch or zero length, [1] start timeout, [2] chid==3.
- err_clr  in  1  clears err_flags; a set in the same cycle wins.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values:
  - fmt_grant=0, rx_valid=0, rx_data/rx_chid/rx_last=0.
  - rx_free=DEPTH, pkt_cnt=0, err_flags=0, busy=0, state=IDLE.
  - FIFO pointers are cleared.
- FSM states: IDLE, GRANT, WAIT_START, RECV.
- IDLE:
  - If fmt_req=1, fmt_length!=0 and fmt_length<=rx_free: latch chid/length, then GRANT.
  - If fmt_req=1 and fmt_length==0: set err_flags[0], issue no grant, remain in IDLE.
  - Otherwise wait.
- GRANT:
  - fmt_grant=1 for exactly this cycle (registered output, one cycle after the request is sampled).
  - Next state is WAIT_START; the timeout counter clears.
- WAIT_START:
  - On fmt_start=1: write word (cnt=1) and go to RECV.
  - If fmt_end is also high, or length==1: the word is last and the packet completes.
  - If the counter reaches TIMEOUT with no start: set err_flags[1] and return to IDLE.
- RECV:
  - Write fmt_data every cycle; cnt increments.
  - The word is last when fmt_end=1 or cnt==latched length.
  - If fmt_end and cnt==length do not coincide, set err_flags[0].
  - After the last word, return to IDLE.
- Packet words are contiguous, one per cycle. Words, starts and ends seen in IDLE/GRANT are ignored.
- Latched chid==3: set err_flags[2]; the packet is still stored.
- FIFO:
  - Entry is {chid, last, data}; a written word is visible on rx_* the next cycle.
  - Pop on rx_valid && rx_ready; simultaneous push and pop leaves the count unchanged.
  - No overflow is possible because space is reserved at grant; the push never checks full.
- pkt_cnt increments in the cycle a last word is written.
- rst during a packet: everything returns to reset values immediately; a partial packet is discarded.

Test Plan:
- Normal packet:
  - Stimulus: fmt_req with chid=1, len=4; fmt_start one cycle after the grant; data 0xA0..0xA3; fmt_end on the 4th word.
  - Required: a single grant pulse two cycles after fmt_req; rx_* delivers 4 words with chid=1; rx_last only on 0xA3; pkt_cnt=1; err_flags=0.
- Backpressure:
  - Stimulus: rx_ready=0; three 8-word packets, then fmt_req len=16.
  - Required: rx_free=8 after the three packets; no grant for len=16 until rx_ready drains at least 8 words; no data loss.
- Length mismatch:
  - Stimulus: len=8 with fmt_end on word 5.
  - Required: 5 words stored, rx_last on word 5, err_flags[0]=1, return to IDLE.
- Timeout:
  - Stimulus: a grant followed by no fmt_start for 15 cycles.
  - Required: err_flags[1]=1, busy=0, no words stored.
- Error handling:
  - Stimulus: chid=3, len=4 packet, then fmt_req with len=0, then err_clr.
  - Required: chid=3 packet stored with err_flags[2]=1; no grant for len=0 and err_flags[0]=1; err_clr returns err_flags to 0.
- Reset mid-packet:
  - Stimulus: assert rst after word 2 of a 4-word packet.
  - Required: rx_valid=0, rx_free=32, pkt_cnt=0 immediately.
